// File: rtl/algo_16m8d_dq_arb_if.sv
// Client request and dealloc-lane bundle for algo_16m8d_dq_arb.
// The master side drives requests and ready. The slave (the arbiter) returns rq_rdy and the lanes.
interface algo_16m8d_dq_arb_if #(
  parameter int NUMREQ  = 4,
  parameter int NUMDQPT = 2,
  parameter int BITADDR = 14
);
  logic                       ready;
  logic [NUMREQ-1:0]          rq_vld;
  logic [NUMREQ*BITADDR-1:0]  rq_adr;
  logic [NUMREQ-1:0]          rq_rdy;
  logic [NUMDQPT-1:0]         dq_vld;
  logic [NUMDQPT*BITADDR-1:0] dq_adr;

  modport master (
    output ready, rq_vld, rq_adr,
    input  rq_rdy, dq_vld, dq_adr
  );

  modport slave (
    input  ready, rq_vld, rq_adr,
    output rq_rdy, dq_vld, dq_adr
  );
endinterface

// File: rtl/algo_16m8d_dq_arb.sv
// Round-robin dealloc arbiter: per-client FIFOs feeding up to NUMDQPT registered dq lanes.
// Optional issue statistic counter enabled by ALGO_16M8D_DQ_ARB_STAT_EN (dq_cnt tied to 0 otherwise).
module algo_16m8d_dq_arb #(
  parameter int NUMREQ  = 4,
  parameter int BITREQ  = 2,
  parameter int NUMDQPT = 2,
  parameter int BITADDR = 14,
  parameter int FIFODEP = 4,
  parameter int BITFIFO = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  algo_16m8d_dq_arb_if.slave    bus,
  output logic                  dq_idle,
  output logic [31:0]           dq_cnt
);
  localparam int CNTW = BITFIFO + 1;

  logic [BITADDR-1:0] mem    [NUMREQ][FIFODEP];
  logic [BITFIFO-1:0] wr_ptr [NUMREQ];
  logic [BITFIFO-1:0] rd_ptr [NUMREQ];
  logic [CNTW-1:0]    cnt    [NUMREQ];
  logic [BITREQ-1:0]  rr_ptr;
  logic [BITREQ-1:0]  rr_nxt;
  logic [NUMREQ-1:0]  push;
  logic [NUMREQ-1:0]  pop;
  logic [NUMDQPT-1:0] lane_v;
  logic [BITREQ-1:0]  lane_sel [NUMDQPT];

  // Ready depends only on registered occupancy, so a full FIFO refuses a push even while popping.
  always_comb begin
    for (int i = 0; i < NUMREQ; i++) begin
      bus.rq_rdy[i] = (cnt[i] != CNTW'(FIFODEP));
      push[i]       = bus.rq_vld[i] & bus.rq_rdy[i];
    end
  end

  always_comb begin
    int               ng;
    logic [BITREQ-1:0] idx;
    ng     = 0;
    idx    = '0;
    pop    = '0;
    lane_v = '0;
    rr_nxt = rr_ptr;
    for (int k = 0; k < NUMDQPT; k++) lane_sel[k] = '0;
    if (bus.ready) begin
      for (int j = 0; j < NUMREQ; j++) begin
        idx = rr_ptr + BITREQ'(j);
        if ((cnt[idx] != '0) && (ng < NUMDQPT)) begin
          pop[idx]     = 1'b1;
          lane_v[ng]   = 1'b1;
          lane_sel[ng] = idx;
          rr_nxt       = idx + BITREQ'(1);
          ng           = ng + 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUMREQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUMREQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + BITFIFO'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + BITFIFO'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CNTW'(1);
          2'b01:   cnt[i] <= cnt[i] - CNTW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      rr_ptr <= rr_nxt;
    end
  end

  // Storage is not reset; flushing is done by clearing the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMREQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.rq_adr[i*BITADDR +: BITADDR];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dq_vld <= '0;
      bus.dq_adr <= '0;
    end else begin
      for (int k = 0; k < NUMDQPT; k++) begin
        bus.dq_vld[k] <= lane_v[k];
        bus.dq_adr[k*BITADDR +: BITADDR] <=
          lane_v[k] ? mem[lane_sel[k]][rd_ptr[lane_sel[k]]] : '0;
      end
    end
  end

  always_comb begin
    dq_idle = ~|bus.dq_vld;
    for (int i = 0; i < NUMREQ; i++) begin
      if (cnt[i] != '0) dq_idle = 1'b0;
    end
  end

`ifdef ALGO_16M8D_DQ_ARB_STAT_EN
  logic [31:0] lane_pc;
  logic [32:0] cnt_sum;

  always_comb begin
    lane_pc = '0;
    for (int k = 0; k < NUMDQPT; k++) lane_pc = lane_pc + 32'(bus.dq_vld[k]);
    cnt_sum = {1'b0, dq_cnt} + {1'b0, lane_pc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dq_cnt <= '0;
    else      dq_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end
`else
  assign dq_cnt = '0;
`endif

endmodule

// File: tb/tb_algo_16m8d_dq_arb.sv
// Directed bench for algo_16m8d_dq_arb: a 2-lane instance plus a 1-lane instance for the alternation case.
module tb_algo_16m8d_dq_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic        idle0, idle1;
  logic [31:0] cnt0, cnt1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  algo_16m8d_dq_arb_if #(.NUMREQ(4), .NUMDQPT(2), .BITADDR(14)) bus  ();
  algo_16m8d_dq_arb_if #(.NUMREQ(4), .NUMDQPT(1), .BITADDR(14)) bus1 ();

  algo_16m8d_dq_arb #(.NUMREQ(4), .BITREQ(2), .NUMDQPT(2), .BITADDR(14), .FIFODEP(4), .BITFIFO(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dq_idle(idle0), .dq_cnt(cnt0));

  algo_16m8d_dq_arb #(.NUMREQ(4), .BITREQ(2), .NUMDQPT(1), .BITADDR(14), .FIFODEP(4), .BITFIFO(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .dq_idle(idle1), .dq_cnt(cnt1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adr(input int i, input logic [13:0] a);
    bus.rq_adr[i*14 +: 14] = a;
  endtask

  task automatic do_reset();
    bus.ready   = 1'b0;
    bus.rq_vld  = '0;
    bus.rq_adr  = '0;
    bus1.ready  = 1'b0;
    bus1.rq_vld = '0;
    bus1.rq_adr = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [31:0] exp_cnt;

  initial begin
    do_reset();
    chk("rst_vld", 32'(bus.dq_vld), 32'h0);
    chk("rst_rdy", 32'(bus.rq_rdy), 32'hF);
    chk("rst_idle", 32'(idle0), 32'h1);
    chk("rst_cnt", cnt0, 32'h0);

    // single push on client 0
    bus.ready  = 1'b1;
    bus.rq_vld = 4'b0001;
    set_adr(0, 14'h0123);
    tick();
    bus.rq_vld = '0;
    chk("s1_busy", 32'(idle0), 32'h0);
    chk("s1_vld_early", 32'(bus.dq_vld), 32'h0);
    tick();
    chk("s1_vld", 32'(bus.dq_vld), 32'h1);
    chk("s1_adr", 32'(bus.dq_adr[13:0]), 32'h0123);
    tick();
    chk("s1_vld_off", 32'(bus.dq_vld), 32'h0);
    chk("s1_idle", 32'(idle0), 32'h1);

    // all four clients push together
    do_reset();
    bus.ready  = 1'b1;
    bus.rq_vld = 4'b1111;
    for (int i = 0; i < 4; i++) set_adr(i, 14'(16'h1000 + i));
    tick();
    bus.rq_vld = '0;
    tick();
    chk("s2_vld_a", 32'(bus.dq_vld), 32'h3);
    chk("s2_l0_a", 32'(bus.dq_adr[13:0]), 32'h1000);
    chk("s2_l1_a", 32'(bus.dq_adr[27:14]), 32'h1001);
    tick();
    chk("s2_vld_b", 32'(bus.dq_vld), 32'h3);
    chk("s2_l0_b", 32'(bus.dq_adr[13:0]), 32'h1002);
    chk("s2_l1_b", 32'(bus.dq_adr[27:14]), 32'h1003);
    chk("s2_rrptr", 32'(dut.rr_ptr), 32'h0);
    tick();
    chk("s2_vld_off", 32'(bus.dq_vld), 32'h0);

    // client 2 overfills while ready is low
    do_reset();
    for (int n = 0; n < 5; n++) begin
      bus.rq_vld = 4'b0100;
      set_adr(2, 14'(16'h0200 + n));
      chk("s3_rdy_in", 32'(bus.rq_rdy[2]), (n < 4) ? 32'h1 : 32'h0);
      tick();
    end
    bus.rq_vld = '0;
    chk("s3_hold", 32'(bus.dq_vld), 32'h0);
    chk("s3_full", 32'(bus.rq_rdy[2]), 32'h0);
    bus.ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("s3_vld", 32'(bus.dq_vld), 32'h1);
      chk("s3_adr", 32'(bus.dq_adr[13:0]), 32'h0200 + 32'(n));
      if (n == 0) chk("s3_rdy_back", 32'(bus.rq_rdy[2]), 32'h1);
    end
    tick();
    chk("s3_drop5", 32'(bus.dq_vld), 32'h0);

    // single-lane instance: clients 1 and 3 alternate
    do_reset();
    bus1.rq_vld = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      bus1.rq_adr[1*14 +: 14] = 14'(16'h0110 + n);
      bus1.rq_adr[3*14 +: 14] = 14'(16'h0310 + n);
      tick();
    end
    bus1.rq_vld = '0;
    bus1.ready  = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("s4_vld", 32'(bus1.dq_vld), 32'h1);
      chk("s4_adr", 32'(bus1.dq_adr), ((n % 2) == 0) ? 32'h0110 + 32'(n/2) : 32'h0310 + 32'(n/2));
    end

    // async reset with entries queued and lanes valid
    do_reset();
    bus.rq_vld = 4'b0011;
    for (int n = 0; n < 3; n++) begin
      set_adr(0, 14'(16'h0500 + n));
      set_adr(1, 14'(16'h0600 + n));
      tick();
    end
    bus.rq_vld = '0;
    bus.ready  = 1'b1;
    tick();
    chk("s5_vld_pre", 32'(bus.dq_vld), 32'h3);
    chk("s5_adr_pre", 32'(bus.dq_adr[13:0]), 32'h0500);
    #2;
    rst = 1'b0;
    #1;
    chk("s5_vld_rst", 32'(bus.dq_vld), 32'h0);
    chk("s5_adr_rst", 32'(bus.dq_adr), 32'h0);
    chk("s5_rdy_rst", 32'(bus.rq_rdy), 32'hF);
    chk("s5_idle_rst", 32'(idle0), 32'h1);
    tick();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("s5_no_stale", 32'(bus.dq_vld), 32'h0);
    end

    // ten cycles of both lanes valid
    do_reset();
    chk("s6_cnt_rst", cnt0, 32'h0);
    bus.rq_vld = 4'b1111;
    for (int i = 0; i < 4; i++) set_adr(i, 14'(16'h0700 + i));
    for (int n = 0; n < 4; n++) tick();
    bus.ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("s6_vld", 32'(bus.dq_vld), 32'h3);
    end
    bus.ready = 1'b0;
    tick();
    bus.rq_vld = '0;
`ifdef ALGO_16M8D_DQ_ARB_STAT_EN
    exp_cnt = 32'd20;
`else
    exp_cnt = 32'd0;
`endif
    chk("s6_vld_off", 32'(bus.dq_vld), 32'h0);
    chk("s6_cnt", cnt0, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/algo_16m8d_dq_arb.md
# algo_16m8d_dq_arb

Deallocation request arbiter for the 16m8d malloc/dealloc memory. Collects free-address requests from NUMREQ independent clients, buffers each in a private FIFO, and issues up to NUMDQPT requests per cycle onto the algo top's dq_vld/dq_adr dealloc ports using a rotating round-robin priority. Sits between the client logic and algo_16m8d_m70_top_wrap. Holds all traffic until the memory asserts ready.

## Interface
- NUMREQ, 4, number of requesting clients
- BITREQ, 2, log2(NUMREQ)
- NUMDQPT, 2, dealloc lanes driven per cycle (1..NUMREQ)
- BITADDR, 14, dealloc address width
- FIFODEP, 4, per-client FIFO depth (power of 2)
- BITFIFO, 2, log2(FIFODEP)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ready  in  1  algo top ready; no issue while 0
- rq_vld  in  NUMREQ  per-client request valid
- rq_adr  in  NUMREQ*BITADDR  per-client address, client i at [i*BITADDR +: BITADDR]
- rq_rdy  out  NUMREQ  per-client FIFO not full
- dq_vld  out  NUMDQPT  dealloc lane valid, to algo top
- dq_adr  out  NUMDQPT*BITADDR  dealloc lane address
- dq_idle  out  1  all FIFOs empty and no lane valid
- dq_cnt  out  32  issued-dealloc statistic counter (see Configuration)

## Operation
- Push: client i writes when rq_vld[i] & rq_rdy[i]. rq_rdy[i] = (count_i != FIFODEP), from count only; a full FIFO refuses push even in a pop cycle.
- rq_vld without rq_rdy: ignored, not held internally; client retains request.
- Arbitration each cycle with ready=1: scan clients rr_ptr, rr_ptr+1, ... mod NUMREQ; first NUMDQPT non-empty clients granted; k-th grant pops its head to lane k. One pop per client per cycle.
- rr_ptr update: (index of last granted client + 1) mod NUMREQ; unchanged if no grant.
- ready=0: no pops, no grants, rr_ptr frozen, dq_vld=0; pushes continue until full.
- Unused lanes: dq_vld[k]=0, dq_adr lane k=0.
- Same-cycle push and pop on one FIFO: both occur, count unchanged; push into empty FIFO not visible to arbiter until next cycle.
- FIFO pointers wrap mod FIFODEP; count width BITFIFO+1.
- dq_idle = all counts 0 & dq_vld==0.
- Reset (asserted any time, including mid-burst): FIFOs flushed, rr_ptr=0, dq_vld=0, dq_adr=0, dq_cnt=0; rq_rdy=all 1 and dq_idle=1 after reset.

## Timing
- dq_vld/dq_adr registered; pop in cycle N appears on lanes in cycle N+1, valid exactly one cycle.
- Minimum latency push->dq_vld: 2 cycles (push edge N, grant N+1, lane visible N+2... i.e., accepted at edge N, on lane after edge N+2).
- ready sampled the cycle the grant is made; ready falling does not cancel lanes already registered.
- Throughput: NUMDQPT addresses/cycle sustained when >=NUMDQPT FIFOs non-empty.
- rq_rdy combinational from registered counts only (no combinational path rq_vld->rq_rdy).

## Configuration
- ALGO_16M8D_DQ_ARB_STAT_EN defined: dq_cnt increments by popcount(dq_vld) each cycle, saturates at 32'hFFFFFFFF, reset to 0.
- Not defined: counter logic absent, dq_cnt tied to 0.

## Test plan
- Reset then client 0 pushes 0x0123 with ready=1 -> dq_vld=2'b01, dq_adr lane0=0x0123 two edges after push, dq_idle=1 next cycle.
- All 4 clients push one address, same cycle, ready=1 -> lanes carry clients 0,1 then next cycle clients 2,3; rr_ptr returns to 0.
- ready=0, client 2 pushes 5 addresses -> rq_rdy[2]=0 after 4th, 5th dropped; ready=1 -> 4 addresses issued in order on lane 0.
- Clients 1 and 3 continuously non-empty with NUMDQPT=1 -> grants strictly alternate 1,3,1,3.
- Reset asserted with 3 entries queued and lanes valid -> dq_vld=0 immediately (async), all rq_rdy=1, no stale address issued after release.
- With ALGO_16M8D_DQ_ARB_STAT_EN, 10 cycles of 2 lanes valid -> dq_cnt=20; without macro dq_cnt=0.
